// File: rtl/irq_gateway_if.sv
// Wishbone classic slave bus bundle used by irq_gateway.
// The gateway takes the slave modport; the bus master (or bench) takes master.
interface irq_gateway_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/irq_gateway.sv
// Interrupt gateway in front of the PLIC: synchronizes raw interrupt lines,
// applies level/edge triggering, tracks IDLE/PENDING/CLAIMED per source and
// counts edges that arrive while a request is outstanding.
module irq_gateway #(
    parameter int          NSRC = 8,
    parameter int          IDW  = 5,
    parameter int          CNTW = 4,
    parameter logic [31:0] BASE = 32'h0C10_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    irq_gateway_if.slave    wb,
    input  logic [NSRC-1:0] irq_src_i,
    output logic [NSRC-1:0] irq_req_o,
    input  logic            claim_i,
    input  logic [IDW-1:0]  claim_id_i,
    input  logic            complete_i,
    input  logic [IDW-1:0]  complete_id_i
);
    typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, CLAIMED = 2'd2} state_t;

    localparam logic [31:0]     ADR_MODE = BASE;
    localparam logic [31:0]     ADR_PEND = BASE + 32'h4;
    localparam logic [31:0]     ADR_CLMD = BASE + 32'h8;
    localparam logic [31:0]     ADR_SEL  = BASE + 32'hC;
    localparam logic [31:0]     ADR_CNT  = BASE + 32'h10;
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    // Slot 0 is reserved, so per-source storage starts at index 1.
    logic [NSRC-1:1]            s1_reg, s2_reg, s3_reg;
    logic [NSRC-1:1]            trig_reg, trig_next;
    logic [NSRC-1:1]            mode_reg;
    logic [IDW-1:0]             sel_reg;
    logic                       ack_reg;
    logic [31:0]                dat_reg, rd_data;
    logic                       access, mode_wr;
    logic [NSRC-1:0]            req_vec, claimed_vec;
    logic [NSRC-1:1][CNTW-1:0]  cnt_all;
    logic                       unused_inputs;

    assign unused_inputs = ^{wb.wb_sel_i, wb.wb_dat_i, irq_src_i[0]};

    assign access  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_reg;
    assign mode_wr = access & wb.wb_we_i & (wb.wb_adr_i == ADR_MODE);

    // Edge mode fires on a rising synchronized level, level mode on the level itself.
    assign trig_next = s2_reg & (~s3_reg | ~mode_reg);

    // Two-flop synchronizer, history flop and registered trigger.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            s3_reg   <= '0;
            trig_reg <= '0;
        end else begin
            s1_reg   <= irq_src_i[NSRC-1:1];
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            trig_reg <= trig_next;
        end
    end

    assign req_vec[0]     = 1'b0;
    assign claimed_vec[0] = 1'b0;
    assign irq_req_o      = req_vec;

    for (genvar gi = 1; gi < NSRC; gi++) begin : g_src
        state_t          state_reg, state_next;
        logic [CNTW-1:0] cnt_reg, cnt_next, cnt_inc;
        logic            req_reg;
        logic            claim_hit, complete_hit, mode_clr;

        // IDs 0 and >= NSRC never match any slot, so they fall out naturally.
        assign claim_hit    = claim_i    && (claim_id_i    == IDW'(gi));
        assign complete_hit = complete_i && (complete_id_i == IDW'(gi));
        assign mode_clr     = mode_wr && (wb.wb_dat_i[gi] != mode_reg[gi]);

        // Next state and edge count; an edge coinciding with a complete nets to zero.
        always_comb begin
            state_next = state_reg;
            cnt_inc    = cnt_reg;
            if (mode_reg[gi] && trig_reg[gi] && (state_reg != IDLE) && (cnt_reg != CNT_MAX))
                cnt_inc = cnt_reg + 1'b1;
            cnt_next = cnt_inc;
            case (state_reg)
                IDLE:    if (trig_reg[gi]) state_next = PENDING;
                PENDING: if (claim_hit) state_next = CLAIMED;
                CLAIMED: begin
                    if (complete_hit) begin
                        if (mode_reg[gi] && (cnt_inc != '0)) begin
                            state_next = PENDING;
                            cnt_next   = cnt_inc - 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
            if (!mode_reg[gi] || mode_clr)
                cnt_next = '0;
        end

        // State, counter and request registers; the request tracks the new state.
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                req_reg   <= 1'b0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                req_reg   <= (state_next == PENDING);
            end
        end

        assign req_vec[gi]     = req_reg;
        assign claimed_vec[gi] = (state_reg == CLAIMED);
        assign cnt_all[gi]     = cnt_reg;
    end

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        case (wb.wb_adr_i)
            ADR_MODE: rd_data = 32'({mode_reg, 1'b0});
            ADR_PEND: rd_data = 32'(req_vec);
            ADR_CLMD: rd_data = 32'(claimed_vec);
            ADR_SEL:  rd_data = 32'(sel_reg);
            ADR_CNT: begin
                for (int i = 1; i < NSRC; i++)
                    if (sel_reg == IDW'(i)) rd_data = 32'(cnt_all[i]);
            end
            default: rd_data = '0;
        endcase
    end

    // Wishbone slave: single-cycle ack, writes and read capture on the ack edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg  <= 1'b0;
            dat_reg  <= '0;
            mode_reg <= '0;
            sel_reg  <= '0;
        end else begin
            ack_reg <= access;
            if (access) begin
                if (wb.wb_we_i) begin
                    if (wb.wb_adr_i == ADR_MODE) mode_reg <= wb.wb_dat_i[NSRC-1:1];
                    if (wb.wb_adr_i == ADR_SEL)  sel_reg  <= wb.wb_dat_i[IDW-1:0];
                end else begin
                    dat_reg <= rd_data;
                end
            end
        end
    end

    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_dat_o = dat_reg;
endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway with an expected-value scoreboard.
module tb_irq_gateway;
    localparam int          NSRC = 8;
    localparam int          IDW  = 5;
    localparam int          CNTW = 4;
    localparam logic [31:0] BASE = 32'h0C10_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] irq_src = '0;
    logic [NSRC-1:0] irq_req;
    logic            claim = 1'b0, complete = 1'b0;
    logic [IDW-1:0]  claim_id = '0, complete_id = '0;

    int n_checks = 0;
    int n_pass   = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    irq_gateway_if wb();

    irq_gateway #(.NSRC(NSRC), .IDW(IDW), .CNTW(CNTW), .BASE(BASE)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb            (wb),
        .irq_src_i     (irq_src),
        .irq_req_o     (irq_req),
        .claim_i       (claim),
        .claim_id_i    (claim_id),
        .complete_i    (complete),
        .complete_id_i (complete_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic check_next(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        n_checks++;
        if (val_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed %h expected queued entry", obs);
            return;
        end
        t = tag_q.pop_front();
        v = val_q.pop_front();
        assert (obs === v) n_pass = n_pass + 1;
        else $error("FAIL %s observed %h expected %h", t, obs, v);
    endtask

    task automatic check_req(input string tag, input logic [NSRC-1:0] exp);
        push_exp(tag, 32'(exp));
        check_next(32'(irq_req));
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
        int waited = 0;
        push_exp("wr_ack", 32'd1);
        wb.wb_adr_i = addr; wb.wb_dat_i = data; wb.wb_we_i = 1'b1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        do begin tick(); waited++; end while (!wb.wb_ack_o && waited < 4);
        check_next(32'(wb.wb_ack_o));
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        push_exp("wr_ack_single", 32'd0);
        tick();
        check_next(32'(wb.wb_ack_o));
        $display("wb write %h <= %h", addr, data);
    endtask

    task automatic wb_read(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        int          waited = 0;
        string       t;
        logic [31:0] v;
        push_exp(tag, exp);
        wb.wb_adr_i = addr; wb.wb_we_i = 1'b0;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        do begin tick(); waited++; end while (!wb.wb_ack_o && waited < 4);
        if (!wb.wb_ack_o) begin
            n_checks++;
            t = tag_q.pop_front();
            v = val_q.pop_front();
            $error("FAIL %s_timeout observed no ack expected ack with %h", t, v);
        end else begin
            $display("wb read %h -> %h (expect %h)", addr, wb.wb_dat_o, exp);
            check_next(wb.wb_dat_o);
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        push_exp("rd_ack_single", 32'd0);
        tick();
        check_next(32'(wb.wb_ack_o));
    endtask

    task automatic do_claim(input logic [IDW-1:0] id);
        claim = 1'b1; claim_id = id;
        tick();
        claim = 1'b0; claim_id = '0;
        $display("claim id %0d", id);
    endtask

    task automatic do_complete(input logic [IDW-1:0] id);
        complete = 1'b1; complete_id = id;
        tick();
        complete = 1'b0; complete_id = '0;
        $display("complete id %0d", id);
    endtask

    task automatic do_both(input logic [IDW-1:0] id);
        claim = 1'b1; claim_id = id; complete = 1'b1; complete_id = id;
        tick();
        claim = 1'b0; claim_id = '0; complete = 1'b0; complete_id = '0;
        $display("claim+complete id %0d", id);
    endtask

    task automatic pulse(input int bit_n);
        irq_src[bit_n] = 1'b1;
        tick();
        irq_src[bit_n] = 1'b0;
        tick();
    endtask

    initial begin
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = 4'hF;
        wb.wb_we_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;

        // Reset with two lines held high
        irq_src = 8'h06;
        rst = 1'b1;
        repeat (3) tick();
        check_req("rst_req", 8'h00);
        push_exp("rst_ack", 32'd0); check_next(32'(wb.wb_ack_o));
        push_exp("rst_dat", 32'd0); check_next(wb.wb_dat_o);
        rst = 1'b0;
        tick(); check_req("rel_e0", 8'h00);
        tick(); check_req("rel_e1", 8'h00);
        tick(); check_req("rel_e2", 8'h00);
        tick(); check_req("rel_e3", 8'h06);

        // Drain both level requests
        irq_src = 8'h00;
        repeat (4) tick();
        do_claim(1); do_claim(2); do_complete(1); do_complete(2);
        check_req("drain", 8'h00);
        wb_read(BASE + 32'h8, "drain_claimed", 32'h0);

        // Level UART
        irq_src[1] = 1'b1;
        repeat (3) tick();
        check_req("lvl_lat3", 8'h00);
        tick(); check_req("lvl_lat4", 8'h02);
        do_claim(1); check_req("lvl_claim", 8'h00);
        wb_read(BASE + 32'h8, "lvl_claimed", 32'h2);
        do_complete(1); check_req("lvl_cmpl_k", 8'h00);
        tick(); check_req("lvl_cmpl_k1", 8'h02);
        do_claim(1);
        irq_src[1] = 1'b0;
        repeat (4) tick();
        do_complete(1); check_req("lvl_drop_k", 8'h00);
        tick(); tick(); check_req("lvl_drop_k2", 8'h00);
        wb_read(BASE + 32'h8, "lvl_drop_claimed", 32'h0);

        // Edge GPIO
        wb_write(BASE, 32'h4);
        pulse(2); tick(); tick();
        check_req("edge_pend", 8'h04);
        do_claim(2); check_req("edge_claim", 8'h00);
        pulse(2); pulse(2);
        repeat (4) tick();
        wb_write(BASE + 32'hC, 32'd2);
        wb_read(BASE + 32'h10, "edge_cnt2", 32'd2);
        do_complete(2); check_req("edge_re1", 8'h04);
        wb_read(BASE + 32'h10, "edge_cnt1", 32'd1);
        do_claim(2); do_complete(2); check_req("edge_re2", 8'h04);
        wb_read(BASE + 32'h10, "edge_cnt0", 32'd0);
        do_claim(2); do_complete(2); check_req("edge_idle", 8'h00);
        wb_read(BASE + 32'h4, "edge_pending", 32'h0);

        // Saturation on source 1
        wb_write(BASE, 32'h2);
        pulse(1); tick(); tick();
        check_req("sat_pend", 8'h02);
        do_claim(1);
        for (int i = 0; i < 20; i++) pulse(1);
        repeat (4) tick();
        wb_write(BASE + 32'hC, 32'd1);
        wb_read(BASE + 32'hC, "sat_sel", 32'd1);
        wb_read(BASE + 32'h10, "sat_cnt", 32'd15);
        wb_write(BASE, 32'h0);
        wb_read(BASE + 32'h10, "sat_clear", 32'd0);
        wb_read(BASE + 32'h8, "sat_state_kept", 32'h2);
        do_complete(1); check_req("sat_done", 8'h00);

        // Boundary IDs
        irq_src[1] = 1'b1;
        repeat (4) tick();
        check_req("bnd_pend", 8'h02);
        do_claim(0); check_req("bnd_claim0", 8'h02);
        do_claim(9); check_req("bnd_claim9", 8'h02);
        do_complete(1); check_req("bnd_cmpl_pend", 8'h02);
        do_complete(2);
        wb_read(BASE + 32'h8, "bnd_cmpl_idle", 32'h0);
        do_both(1); check_req("bnd_both_pend", 8'h00);
        wb_read(BASE + 32'h8, "bnd_both_claimed", 32'h2);
        do_both(1); check_req("bnd_both_clmd", 8'h00);
        tick(); check_req("bnd_both_repend", 8'h02);

        // Wishbone map
        wb_write(BASE, 32'h1234_5678);
        wb_read(BASE, "wb_mode", 32'h78);
        wb_read(BASE + 32'h20, "wb_unmapped", 32'h0);
        wb_write(BASE + 32'h20, 32'hFFFF_FFFF);
        wb_read(BASE, "wb_mode_kept", 32'h78);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
